// File: rtl/run_enc_ctrl_pkg.sv
// Shared types and constants for the CAVLC run_before sequencer.
// State codes, encoder cycle codes and field widths.
package run_enc_ctrl_pkg;

    localparam int RB_W        = 4;
    localparam int CODE_W      = 14;
    localparam int LEN_W       = 4;
    localparam int ENTRY_W     = CODE_W + LEN_W;
    localparam int BLK_ENTRIES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] ENC_IDLE  = 4'd0;
    localparam logic [3:0] ENC_FIRST = 4'd1;
    localparam logic [3:0] ENC_LAST  = 4'd8;

    // Encode cycles for a block: ceil((tc-1)/2) == tc/2 for tc >= 1.
    function automatic logic [3:0] enc_cycles(
        input logic [4:0] tc,
        input logic [3:0] tz
    );
        if (tc >= 5'd2 && tz != 4'd0)
            return tc[4:1];
        return ENC_IDLE;
    endfunction

endpackage

// File: rtl/run_enc_ctrl_fifo.sv
// Synchronous FIFO holding {code, length} entries.
// Exposes occupancy so the sequencer can admit whole blocks.
module run_code_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/run_enc_ctrl.sv
// Sequencer driving a two-codes-per-cycle run_before encoder.
// Optional RUN_ENC_CTRL_BITCNT_EN adds the blk_bits length sum.
module run_enc_ctrl
    import run_enc_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                start_ready,
    input  logic [4:0]          totalcoeff_i,
    input  logic [3:0]          totalzeros_i,
    input  logic [63:0]         runbefore_i,
    output logic                enc_en,
    output logic [3:0]          enc_state,
    output logic [3:0]          enc_totalzeros,
    output logic [4:0]          enc_totalcoeff,
    output logic [RB_W-1:0]     runbefore0,
    output logic [RB_W-1:0]     runbefore1,
    input  logic [CODE_W-1:0]   run_code,
    input  logic [LEN_W-1:0]    run_len,
    output logic                code_valid,
    output logic [CODE_W-1:0]   code_data,
    output logic [LEN_W-1:0]    code_len,
    input  logic                code_ready,
`ifdef RUN_ENC_CTRL_BITCNT_EN
    output logic [7:0]          blk_bits,
`endif
    output logic                done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t             state_q, state_d;
    logic [3:0]         k_q, k_d;
    logic [3:0]         zl_q, zl_d;
    logic [3:0]         n_q;
    logic [4:0]         tc_q;
    logic [3:0]         tz_q;
    logic [63:0]        rb_q;
    logic [2:0]         kidx;
    logic [RB_W-1:0]    rb0, rb1;
    logic [4:0]         rb_sum;
    logic [3:0]         zl_next;
    logic               accept;
    logic               push;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    // A block is admitted only when all its codes are sure to fit.
    assign start_ready = (state_q == ST_IDLE) &&
        (fifo_count <= CW'(FIFO_DEPTH - BLK_ENTRIES));
    assign accept = start && start_ready;

    assign kidx   = 3'(k_q - 4'd1);
    assign rb0    = rb_q[{kidx, 3'b000} +: RB_W];
    assign rb1    = rb_q[{kidx, 3'b100} +: RB_W];
    assign rb_sum = {1'b0, rb0} + {1'b0, rb1};
    assign zl_next = ({1'b0, zl_q} > rb_sum) ?
        4'({1'b0, zl_q} - rb_sum) : 4'd0;

    assign enc_totalzeros = tz_q;
    assign enc_totalcoeff = tc_q;
    assign push = enc_en && (run_len != '0);

    // FSM state, cycle index and zeros-left mirror.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= ENC_IDLE;
            zl_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            zl_q    <= zl_d;
        end
    end

    // Block parameters captured at accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q <= '0;
            tz_q <= '0;
            rb_q <= '0;
            n_q  <= '0;
        end else if (accept) begin
            tc_q <= totalcoeff_i;
            tz_q <= totalzeros_i;
            rb_q <= runbefore_i;
            n_q  <= enc_cycles(totalcoeff_i, totalzeros_i);
        end
    end

    // Next state and encoder-facing outputs.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        zl_d       = zl_q;
        enc_en     = 1'b0;
        enc_state  = ENC_IDLE;
        runbefore0 = '0;
        runbefore1 = '0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    k_d  = ENC_FIRST;
                    zl_d = totalzeros_i;
                    if (enc_cycles(totalcoeff_i, totalzeros_i) == ENC_IDLE)
                        state_d = ST_DONE;
                    else
                        state_d = ST_ENC;
                end
            end
            ST_ENC: begin
                enc_en     = 1'b1;
                enc_state  = k_q;
                runbefore0 = rb0;
                runbefore1 = rb1;
                zl_d       = zl_next;
                if (k_q == n_q || k_q == ENC_LAST || zl_next == '0)
                    state_d = ST_DONE;
                else
                    k_d = k_q + 4'd1;
            end
            ST_DONE: begin
                done    = 1'b1;
                k_d     = ENC_IDLE;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef RUN_ENC_CTRL_BITCNT_EN
    logic [7:0] bits_q;

    // Running sum of pushed code lengths for the current block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bits_q <= '0;
        else if (accept)
            bits_q <= '0;
        else if (push)
            bits_q <= bits_q + 8'(run_len);
    end

    assign blk_bits = bits_q;
`endif

    run_code_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .din  ({run_code, run_len}),
        .pop  (code_ready),
        .dout (head),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign code_valid = !fifo_empty;
    assign code_data  = head[ENTRY_W-1:LEN_W];
    assign code_len   = head[LEN_W-1:0];

endmodule
